writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Writeback stage directly upstream of the integer register file; drives its write port (wrt_high_enable, destn_reg, destn_data).
- Merges two result sources: ALU results and load responses from the data cache. Load responses are never stalled.
- ALU results are buffered in a 2-entry FIFO.
- Loads are shifted, then sign- or zero-extended to 64 bits per funct3.
- Exports a pending-destination mask for the hazard/forwarding logic.

Parameters:
- XLEN, 64, datapath width.
- FIFO_DEPTH, 2, ALU result buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid & alu_ready.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- ld_valid  in  1  load response present; no ready signal, always accepted.
- ld_rd  in  5  load destination register.
- ld_data  in  XLEN  raw aligned 64-bit memory doubleword.
- ld_funct3  in  3  load type.
- ld_offset  in  3  byte offset of the access within the doubleword.
- wrt_high_enable  out  1  register file write enable.
- destn_reg  out  5  register file write address.
- destn_data  out  XLEN  register file write data.
- ld_err  out  1  one-cycle pulse: illegal ld_funct3 was received.
- pending_mask  out  32  bit i set while an un-written result for register i is held in the FIFO or output register.

Behaviour:
- Reset (synchronous):
  - FIFO emptied.
  - wrt_high_enable, destn_reg, destn_data, ld_err, pending_mask all 0.
  - alu_ready is 1 in the first cycle after reset.
  - Reset asserted mid-operation discards all buffered results; nothing is written.
- Output register: wrt_high_enable, destn_reg and destn_data are registered. Each cycle exactly one of the following loads them:
  1. Load response (highest priority).
  2. Else the FIFO head, which is popped.
  3. Else the ALU bypass, when alu_valid & alu_ready and the FIFO is empty.
  4. Else wrt_high_enable <= 0. destn_reg and destn_data hold their values.
- Latency:
  - Load sampled at edge N: visible on the write port during cycle N+1.
  - ALU bypass: same 1-cycle latency as a load.
  - A buffered ALU entry is written 1 cycle after the first cycle with no ld_valid.
- ALU acceptance:
  - alu_ready = (FIFO count < FIFO_DEPTH), computed from the current count only. It stays 0 when full, even if a pop occurs this cycle.
  - An accepted ALU result that is not bypassed is enqueued.
  - Enqueue and pop in the same cycle are legal; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Results are written in acceptance order within each source. No ordering is guaranteed between sources; the issue logic owns WAW ordering.
- x0 suppression:
  - An accepted result with rd == 0 is dropped.
  - It is not enqueued, does not assert wrt_high_enable, and does not set pending_mask.
  - An ALU result to x0 still completes its handshake.
- Load extension (shifted = ld_data >> (8*ld_offset)):
  - 000 LB: sign-extend bits [7:0].
  - 001 LH: sign-extend [15:0].
  - 010 LW: sign-extend [31:0].
  - 011 LD: full 64 bits.
  - 100 LBU: zero-extend [7:0].
  - 101 LHU: zero-extend [15:0].
  - 110 LWU: zero-extend [31:0].
  - 111: destn_data <= 0, write still performed, ld_err pulses high in cycle N+1.
- ld_offset alignment is guaranteed upstream and is not checked.
- pending_mask is combinational: OR of the one-hot rd of each valid FIFO entry, plus one-hot destn_reg when wrt_high_enable is 1. Duplicate rd values OR together.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN and REG_ADDR_W = 5.
  - Load funct3 encodings as a typed enum (LB, LH, LW, LD, LBU, LHU, LWU).
  - wb_entry_t struct {rd, data}.
- Sub-module load_extend: purely combinational; inputs ld_data, ld_offset, ld_funct3; outputs ext_data and illegal.
- FIFO and arbitration stay inline in writeback_unit.

Test Plan:
- Reset, then a single ALU result rd=5, data=0x1234 with ld_valid=0 -> next cycle wrt_high_enable=1, destn_reg=5, destn_data=0x1234, pending_mask=0x20. The following cycle wrt_high_enable=0.
- ld_data=0x8877665544332211, offset=7, funct3=LB, rd=10 -> destn_data=0xFFFFFFFFFFFFFF88. Same stimulus with LBU -> 0x88. Offset=4 with LW -> 0xFFFFFFFF88776655.
- ld_valid held high 4 cycles while ALU offers rd=1,2,3 -> alu_ready drops after 2 accepts. The 4 loads are written first, then ALU rd=1 then rd=2 in consecutive cycles. rd=3 is accepted once space frees.
- ALU rd=0 and load rd=0 -> both handshakes complete; wrt_high_enable stays 0; pending_mask stays 0.
- Load with funct3=111, rd=7 -> destn_data=0 to reg 7, ld_err=1 for exactly one cycle.
- FIFO holding 2 entries, then reset asserted for 1 cycle -> no writes afterwards, alu_ready=1, pending_mask=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared integer-pipeline types: widths, load funct3 encodings, writeback entry.
package riscv_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;

  // Load funct3 encodings; 3'b111 is the one illegal value
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } ld_funct3_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/load_extend.sv
// Aligns a load doubleword to its byte offset and sign/zero-extends it per funct3.
module load_extend
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] ld_data,
  input  logic [2:0]      ld_offset,
  input  logic [2:0]      ld_funct3,
  output logic [XLEN-1:0] ext_data,
  output logic            illegal
);

  logic [XLEN-1:0] shifted;

  // Shift the addressed byte down to bit 0, then extend to full width
  always_comb begin
    shifted  = ld_data >> {ld_offset, 3'b000};
    ext_data = '0;
    illegal  = 1'b0;
    case (ld_funct3)
      LB:      ext_data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      LH:      ext_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LW:      ext_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      LD:      ext_data = shifted;
      LBU:     ext_data = {{(XLEN-8){1'b0}},  shifted[7:0]};
      LHU:     ext_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      LWU:     ext_data = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: merges load responses and buffered ALU results onto the register-file write port.
module writeback_unit
  import riscv_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_valid,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  input  logic [2:0]            ld_funct3,
  input  logic [2:0]            ld_offset,
  output logic                  wrt_high_enable,
  output logic [REG_ADDR_W-1:0] destn_reg,
  output logic [XLEN-1:0]       destn_data,
  output logic                  ld_err,
  output logic [31:0]           pending_mask
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  wb_entry_t        fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic [XLEN-1:0]  ld_ext;
  logic             ld_illegal;

  logic             alu_fire_c;
  logic             alu_keep_c;
  logic             ld_keep_c;
  logic             pop_c;
  logic             bypass_c;
  logic             push_c;
  wb_entry_t        head_c;
  logic [PTR_W-1:0] pm_idx_c;

  load_extend u_load_extend (
    .ld_data   (ld_data),
    .ld_offset (ld_offset),
    .ld_funct3 (ld_funct3),
    .ext_data  (ld_ext),
    .illegal   (ld_illegal)
  );

  // Ready depends on current occupancy only, so a full FIFO never accepts even while popping
  assign alu_ready = (count_q < CNT_W'(FIFO_DEPTH));

  // Arbitration: load first, then FIFO head, then bypass of a fresh ALU result into an empty FIFO
  always_comb begin
    alu_fire_c = alu_valid & alu_ready;
    alu_keep_c = alu_fire_c & (alu_rd != '0);
    ld_keep_c  = ld_valid & (ld_rd != '0);
    pop_c      = ~ld_valid & (count_q != '0);
    bypass_c   = ~ld_valid & (count_q == '0) & alu_keep_c;
    push_c     = alu_keep_c & ~bypass_c;
    head_c     = fifo_q[rd_ptr_q];
  end

  // FIFO storage; contents are meaningless outside the valid window, so no reset
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_q[wr_ptr_q] <= '{rd: alu_rd, data: alu_data};
    end
  end

  // FIFO pointers, occupancy and the registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      wrt_high_enable <= 1'b0;
      destn_reg       <= '0;
      destn_data      <= '0;
      ld_err          <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      ld_err  <= ld_valid & ld_illegal;

      if (ld_valid) begin
        wrt_high_enable <= ld_keep_c;
        if (ld_keep_c) begin
          destn_reg  <= ld_rd;
          destn_data <= ld_ext;
        end
      end else if (pop_c) begin
        wrt_high_enable <= 1'b1;
        destn_reg       <= head_c.rd;
        destn_data      <= head_c.data;
      end else if (bypass_c) begin
        wrt_high_enable <= 1'b1;
        destn_reg       <= alu_rd;
        destn_data      <= alu_data;
      end else begin
        wrt_high_enable <= 1'b0;
      end
    end
  end

  // Destinations still in flight: valid FIFO entries plus the output register
  always_comb begin
    pending_mask = '0;
    pm_idx_c     = '0;
    for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
      pm_idx_c = rd_ptr_q + PTR_W'(k);
      if (CNT_W'(k) < count_q) begin
        pending_mask = pending_mask | (32'd1 << fifo_q[pm_idx_c].rd);
      end
    end
    if (wrt_high_enable) begin
      pending_mask = pending_mask | (32'd1 << destn_reg);
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus random traffic against a queue model.
module tb_writeback_unit;
  import riscv_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [63:0] ld_data;
  logic [2:0]  ld_funct3;
  logic [2:0]  ld_offset;
  logic        wrt_high_enable;
  logic [4:0]  destn_reg;
  logic [63:0] destn_data;
  logic        ld_err;
  logic [31:0] pending_mask;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  wb_entry_t   mq[$];
  logic        exp_we;
  logic [4:0]  exp_reg;
  logic [63:0] exp_data;
  logic        exp_err;

  writeback_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_rd          (alu_rd),
    .alu_data        (alu_data),
    .ld_valid        (ld_valid),
    .ld_rd           (ld_rd),
    .ld_data         (ld_data),
    .ld_funct3       (ld_funct3),
    .ld_offset       (ld_offset),
    .wrt_high_enable (wrt_high_enable),
    .destn_reg       (destn_reg),
    .destn_data      (destn_data),
    .ld_err          (ld_err),
    .pending_mask    (pending_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Loaded value as the ISA defines it: pick bytes at offset, extend to 64 bits
  function automatic logic [63:0] ext_model(input logic [63:0] d, input logic [2:0] off,
                                            input logic [2:0] f3);
    logic [63:0] s;
    logic [63:0] m;
    logic [63:0] v;
    int          w;
    bit          sgn;
    s = d >> (int'(off) * 8);
    case (f3)
      3'd0: begin w = 8;  sgn = 1'b1; end
      3'd1: begin w = 16; sgn = 1'b1; end
      3'd2: begin w = 32; sgn = 1'b1; end
      3'd3: begin w = 64; sgn = 1'b0; end
      3'd4: begin w = 8;  sgn = 1'b0; end
      3'd5: begin w = 16; sgn = 1'b0; end
      3'd6: begin w = 32; sgn = 1'b0; end
      default: return 64'd0;
    endcase
    if (w == 64) return s;
    m = (64'd1 << w) - 64'd1;
    v = s & m;
    if (sgn && v[w-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] model_pending();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) m = m | (32'd1 << mq[i].rd);
    if (exp_we) m = m | (32'd1 << exp_reg);
    return m;
  endfunction

  // One clock: drive inputs, check pre-edge combinational outputs, advance model, check post-edge outputs
  task automatic step(input logic r, input logic av, input logic [4:0] ard, input logic [63:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [63:0] ldat,
                      input logic [2:0] f3, input logic [2:0] off, output bit acc);
    wb_entry_t e;
    reset = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_data = ldat; ld_funct3 = f3; ld_offset = off;
    #1;
    acc = av && (mq.size() < DEPTH);
    if (!r) begin
      chk("alu_ready", 64'(alu_ready), 64'(mq.size() < DEPTH));
      chk("pending_pre", 64'(pending_mask), 64'(model_pending()));
    end
    if (r) begin
      mq.delete();
      exp_we = 1'b0; exp_reg = '0; exp_data = '0; exp_err = 1'b0;
      acc = 1'b0;
    end else begin
      exp_err = lv && (f3 == 3'b111);
      if (lv) begin
        exp_we = (lrd != 0);
        if (lrd != 0) begin exp_reg = lrd; exp_data = ext_model(ldat, off, f3); end
        if (acc && ard != 0) mq.push_back('{rd: ard, data: ad});
      end else if (mq.size() != 0) begin
        e = mq.pop_front();
        exp_we = 1'b1; exp_reg = e.rd; exp_data = e.data;
        if (acc && ard != 0) mq.push_back('{rd: ard, data: ad});
      end else if (acc && ard != 0) begin
        exp_we = 1'b1; exp_reg = ard; exp_data = ad;
      end else begin
        exp_we = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("wrt_high_enable", 64'(wrt_high_enable), 64'(exp_we));
    chk("destn_reg", 64'(destn_reg), 64'(exp_reg));
    chk("destn_data", destn_data, exp_data);
    chk("ld_err", 64'(ld_err), 64'(exp_err));
    chk("pending_post", 64'(pending_mask), 64'(model_pending()));
  endtask

  task automatic idle(input logic r);
    bit a;
    step(r, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 3'd0, 3'd0, a);
  endtask

  initial begin
    bit          acc;
    int          n_acc;
    logic [4:0]  next_rd;
    logic [63:0] pat;
    pat = 64'h8877665544332211;

    // Reset and post-reset state
    idle(1'b1);
    chk("reset_we", 64'(wrt_high_enable), 64'd0);
    chk("reset_mask", 64'(pending_mask), 64'd0);
    chk("reset_ready", 64'(alu_ready), 64'd1);

    // Single ALU result bypasses in one cycle
    step(1'b0, 1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0, 3'd0, 3'd0, acc);
    chk("bypass_we", 64'(wrt_high_enable), 64'd1);
    chk("bypass_reg", 64'(destn_reg), 64'd5);
    chk("bypass_data", destn_data, 64'h1234);
    chk("bypass_mask", 64'(pending_mask), 64'h20);
    idle(1'b0);
    chk("bypass_we_drop", 64'(wrt_high_enable), 64'd0);

    // Load extension cases
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd10, pat, 3'b000, 3'd7, acc);
    chk("lb_off7", destn_data, 64'hFFFFFFFFFFFFFF88);
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd10, pat, 3'b100, 3'd7, acc);
    chk("lbu_off7", destn_data, 64'h88);
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd10, pat, 3'b010, 3'd4, acc);
    chk("lw_off4", destn_data, 64'hFFFFFFFF88776655);

    // Loads hold off the FIFO while ALU results back up
    n_acc = 0;
    next_rd = 5'd1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, next_rd, 64'(100 + next_rd), 1'b1, 5'(11 + i), pat, 3'b011, 3'd0, acc);
      chk("stall_load_reg", 64'(destn_reg), 64'(11 + i));
      if (acc) begin n_acc++; next_rd = next_rd + 5'd1; end
    end
    chk("stall_accepts", 64'(n_acc), 64'd2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, (next_rd <= 5'd3), next_rd, 64'(100 + next_rd), 1'b0, 5'd0, 64'd0, 3'd0, 3'd0, acc);
      chk("drain_reg", 64'(destn_reg), 64'(i + 1));
      if (acc) next_rd = next_rd + 5'd1;
    end
    chk("rd3_accepted", 64'(next_rd), 64'd4);
    idle(1'b0);

    // x0 destinations complete but never write
    step(1'b0, 1'b1, 5'd0, 64'hDEAD, 1'b1, 5'd0, pat, 3'b011, 3'd0, acc);
    chk("x0_handshake", 64'(acc), 64'd1);
    chk("x0_we", 64'(wrt_high_enable), 64'd0);
    chk("x0_mask", 64'(pending_mask), 64'd0);
    step(1'b0, 1'b1, 5'd0, 64'hBEEF, 1'b0, 5'd0, 64'd0, 3'd0, 3'd0, acc);
    chk("x0_alu_we", 64'(wrt_high_enable), 64'd0);

    // Illegal funct3 writes zero and pulses ld_err
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, pat, 3'b111, 3'd0, acc);
    chk("illegal_data", destn_data, 64'd0);
    chk("illegal_reg", 64'(destn_reg), 64'd7);
    chk("illegal_err", 64'(ld_err), 64'd1);
    idle(1'b0);
    chk("illegal_err_pulse", 64'(ld_err), 64'd0);

    // Reset discards a full FIFO
    step(1'b0, 1'b1, 5'd20, 64'd20, 1'b1, 5'd8, pat, 3'b011, 3'd0, acc);
    step(1'b0, 1'b1, 5'd21, 64'd21, 1'b1, 5'd9, pat, 3'b011, 3'd0, acc);
    chk("full_ready", 64'(alu_ready), 64'd0);
    idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      chk("post_reset_we", 64'(wrt_high_enable), 64'd0);
      chk("post_reset_ready", 64'(alu_ready), 64'd1);
      chk("post_reset_mask", 64'(pending_mask), 64'd0);
    end

    // Random mixed traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 63) == 0),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), {$urandom, $urandom},
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), acc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
